// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry helpers for the set-associative
// data cache controller.
//   state_t  - controller FSM states
//   LINE_W   - cache line width in bits (one memory beat)
//   WORD_W   - CPU word width in bits
//   OFFSET_W - byte-offset bits within a line
//   index_w  - index field width for a given set count
//   tag_w    - tag field width for a given set count (32-bit addresses)
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OFFSET_W = 5;

    function automatic int unsigned index_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned sets);
        return 32 - OFFSET_W - $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// dcache_lru: true-LRU age tracking for every set of the cache.
//   clk_i, rst_i   - clock, asynchronous active-high reset (ages = way index)
//   set_i          - set being looked up / updated
//   access_i       - strobe: mark access_way_i as most recently used
//   access_way_i   - way touched by the access
//   valid_i        - valid bits of set_i, one per way
//   victim_o       - lowest-index invalid way, else the oldest way
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned SETS = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [index_w(SETS)-1:0]   set_i,
    input  logic                       access_i,
    input  logic [$clog2(WAYS)-1:0]    access_way_i,
    input  logic [WAYS-1:0]            valid_i,
    output logic [$clog2(WAYS)-1:0]    victim_o
);

    localparam int unsigned WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] old_age;

    assign old_age = age_q[set_i][access_way_i];

    // Ages stay a permutation of 0..WAYS-1: only ways younger than the
    // accessed one move up, and the accessed way drops to 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (access_i) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == access_way_i) begin
                    age_q[set_i][w] <= '0;
                end else if (age_q[set_i][w] < old_age) begin
                    age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic found;
        found    = 1'b0;
        victim_o = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !valid_i[w]) begin
                victim_o = WAY_W'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[set_i][w] == WAY_W'(WAYS - 1)) begin
                    victim_o = WAY_W'(w);
                end
            end
        end
    end

endmodule

// File: rtl/dcache_sa_controller.sv
// dcache_sa_controller: N-way set-associative, write-back, write-allocate
// data cache controller for the MEM stage.
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   cpu_addr_i/data_i     - CPU byte address and store data
//   cpu_MemRead_i/Write_i - load / store strobes (store wins if both)
//   cpu_data_o            - load data on a read hit, else 0
//   cpu_stall_o           - pipeline freeze while a miss is serviced
//   mem_data_i, mem_ack_i - refill line and one-cycle completion pulse
//   mem_data_o, mem_addr_o, mem_enable_o, mem_write_o - memory request
//   hit_count_o, miss_count_o - wrapping performance counters
module dcache_sa_controller
    import dcache_pkg::*;
#(
    parameter int unsigned WAYS    = 2,
    parameter int unsigned SETS    = 16,
    parameter int unsigned COUNT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    input  logic                cpu_MemRead_i,
    input  logic                cpu_MemWrite_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic [31:0]         mem_addr_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [COUNT_W-1:0]  hit_count_o,
    output logic [COUNT_W-1:0]  miss_count_o
);

    localparam int unsigned IDX_W = index_w(SETS);
    localparam int unsigned TAG_W = tag_w(SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);

    state_t              state_q;
    logic                valid_q [WAYS][SETS];
    logic                dirty_q [WAYS][SETS];
    logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
    logic [LINE_W-1:0]   line_q  [WAYS][SETS];
    logic [WAY_W-1:0]    victim_q;
    logic [LINE_W-1:0]   refill_q;
    logic                retry_q;

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [2:0]          word_sel;
    logic                req;
    logic                is_write;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAYS-1:0]     set_valid;
    logic [WAY_W-1:0]    victim_way;
    logic                lookup_hit;
    logic                lookup_miss;
    logic                addr_unused;

    assign req_idx     = cpu_addr_i[OFFSET_W +: IDX_W];
    assign req_tag     = cpu_addr_i[31 -: TAG_W];
    assign word_sel    = cpu_addr_i[OFFSET_W-1:2];
    assign addr_unused = ^cpu_addr_i[1:0];
    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_write    = cpu_MemWrite_i;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        set_valid = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_q[w][req_idx];
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign lookup_hit  = (state_q == IDLE) && req && hit;
    assign lookup_miss = (state_q == IDLE) && req && !hit;

    dcache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .set_i        (req_idx),
        .access_i     (lookup_hit || (state_q == REFILL)),
        .access_way_i ((state_q == REFILL) ? victim_q : hit_way),
        .valid_i      (set_valid),
        .victim_o     (victim_way)
    );

    // Outputs forced to 0 while reset is asserted so a reset mid-miss
    // releases the pipeline in the same cycle.
    assign cpu_stall_o = !rst_i && ((state_q != IDLE) || lookup_miss);

    always_comb begin
        cpu_data_o = '0;
        if (!rst_i && lookup_hit && !is_write) begin
            cpu_data_o = line_q[hit_way][req_idx][32'(word_sel) * WORD_W +: WORD_W];
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (state_q == REFILL) begin
            tag_q[victim_q][req_idx]  <= req_tag;
            line_q[victim_q][req_idx] <= refill_q;
        end else if (lookup_hit && is_write) begin
            line_q[hit_way][req_idx][32'(word_sel) * WORD_W +: WORD_W] <= cpu_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            refill_q     <= '0;
            retry_q      <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            hit_count_o  <= '0;
            miss_count_o <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // The hit that completes a refilled request was already
                    // counted as a miss.
                    retry_q <= 1'b0;
                    if (lookup_hit) begin
                        if (!retry_q) begin
                            hit_count_o <= hit_count_o + 1'b1;
                        end
                        if (is_write) begin
                            dirty_q[hit_way][req_idx] <= 1'b1;
                        end
                    end else if (lookup_miss) begin
                        miss_count_o <= miss_count_o + 1'b1;
                        victim_q     <= victim_way;
                        mem_enable_o <= 1'b1;
                        if (valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx]) begin
                            state_q     <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_q[victim_way][req_idx], req_idx, {OFFSET_W{1'b0}}};
                            mem_data_o  <= line_q[victim_way][req_idx];
                        end else begin
                            state_q     <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                        mem_data_o  <= '0;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q      <= REFILL;
                        refill_q     <= mem_data_i;
                        mem_enable_o <= 1'b0;
                        mem_addr_o   <= '0;
                    end
                end
                REFILL: begin
                    state_q                    <= IDLE;
                    valid_q[victim_q][req_idx] <= 1'b1;
                    dirty_q[victim_q][req_idx] <= 1'b0;
                    retry_q                    <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_sa_controller.sv
module tb_dcache_sa_controller;

    localparam int unsigned WAYS    = 2;
    localparam int unsigned SETS    = 16;
    localparam int unsigned COUNT_W = 4;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [31:0]        cpu_addr_i;
    logic [31:0]        cpu_data_i;
    logic               cpu_MemRead_i;
    logic               cpu_MemWrite_i;
    logic [31:0]        cpu_data_o;
    logic               cpu_stall_o;
    logic [255:0]       mem_data_i;
    logic               mem_ack_i;
    logic [255:0]       mem_data_o;
    logic [31:0]        mem_addr_o;
    logic               mem_enable_o;
    logic               mem_write_o;
    logic [COUNT_W-1:0] hit_count_o;
    logic [COUNT_W-1:0] miss_count_o;

    dcache_sa_controller #(
        .WAYS    (WAYS),
        .SETS    (SETS),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_data_o     (mem_data_o),
        .mem_addr_o     (mem_addr_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- backing memory ----------------
    logic [255:0] mem_m [logic [26:0]];

    function automatic logic [255:0] mem_peek(input logic [26:0] ln);
        logic [255:0] r;
        if (mem_m.exists(ln)) return mem_m[ln];
        for (int k = 0; k < 8; k++)
            r[k*32 +: 32] = {ln[15:0], 16'h0} ^ (32'(k) * 32'h9E37_79B9) ^ {5'b0, ln};
        return r;
    endfunction

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    txn_t        txn_q[$];
    int unsigned lat_next = 0;
    bit          hold_ack = 0;
    bit          noise_en = 0;

    initial begin : responder
        int unsigned wait_cnt;
        bit          busy;
        txn_t        t;
        wait_cnt   = 0;
        busy       = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (rst_i || !mem_enable_o) begin
                busy = 0;
                if (noise_en && !rst_i && $urandom_range(0, 3) == 0) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = {8{$urandom}};
                end
            end else begin
                if (!busy) begin
                    busy     = 1;
                    wait_cnt = lat_next;
                    t.wr     = mem_write_o;
                    t.addr   = mem_addr_o;
                    t.data   = mem_data_o;
                    txn_q.push_back(t);
                end
                if (!hold_ack) begin
                    if (wait_cnt == 0) begin
                        if (mem_write_o) mem_m[mem_addr_o[31:5]] = mem_data_o;
                        else             mem_data_i = mem_peek(mem_addr_o[31:5]);
                        mem_ack_i = 1'b1;
                        busy      = 0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // ---------------- reference model: resident lines per set, LRU by timestamp ----------------
    bit           m_valid [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    logic [26:0]  m_line  [SETS][WAYS];
    logic [255:0] m_data  [SETS][WAYS];
    int unsigned  m_used  [SETS][WAYS];
    int unsigned  now_t = 0;
    int unsigned  m_hits = 0;
    int unsigned  m_misses = 0;

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_i          = 1'b1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        @(negedge clk_i);
        check("rst_stall", cpu_stall_o, 0);
        check("rst_cpu_data", cpu_data_o, 0);
        check("rst_mem_en", mem_enable_o, 0);
        check("rst_mem_wr", mem_write_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_data", mem_data_o, 0);
        check("rst_hits", hit_count_o, 0);
        check("rst_misses", miss_count_o, 0);
        rst_i = 1'b0;
        model_clear();
    endtask

    task automatic access(input logic [31:0] addr, input bit wr, input bit both,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic first_stall);
        logic [26:0]  ln;
        int unsigned  s, w, slot, k, n, exp_n;
        bit           hit, wb;
        logic [26:0]  wb_line;
        logic [255:0] wb_data, fill;
        ln   = addr[31:5];
        s    = 32'(ln[3:0]);
        w    = 32'(addr[4:2]);
        hit  = 0;
        slot = 0;
        for (int unsigned i = 0; i < WAYS; i++)
            if (m_valid[s][i] && m_line[s][i] == ln) begin
                hit  = 1;
                slot = i;
            end
        txn_q.delete();
        now_t++;
        @(posedge clk_i); #1;
        cpu_addr_i     = addr;
        cpu_data_i     = wdata;
        cpu_MemWrite_i = wr;
        cpu_MemRead_i  = !wr || both;
        @(negedge clk_i);
        first_stall = cpu_stall_o;
        if (hit) begin
            check("hit_stall", cpu_stall_o, 0);
            m_hits++;
        end else begin
            check("miss_stall", cpu_stall_o, 1);
            m_misses++;
            slot = WAYS;
            for (int unsigned i = 0; i < WAYS; i++)
                if (!m_valid[s][i] && slot == WAYS) slot = i;
            if (slot == WAYS) begin
                slot = 0;
                for (int unsigned i = 1; i < WAYS; i++)
                    if (m_used[s][i] < m_used[s][slot]) slot = i;
            end
            wb      = m_valid[s][slot] && m_dirty[s][slot];
            wb_line = m_line[s][slot];
            wb_data = m_data[s][slot];
            fill    = mem_peek(ln);
            exp_n   = lat_next + 3 + (wb ? lat_next + 1 : 0);
            n = 1;
            while (n < 400) begin
                @(negedge clk_i);
                if (!cpu_stall_o) break;
                n++;
            end
            check("stall_cycles", n, exp_n);
            check("txn_count", txn_q.size(), wb ? 2 : 1);
            k = 0;
            if (wb && txn_q.size() > 0) begin
                check("wb_write", txn_q[0].wr, 1);
                check("wb_addr", txn_q[0].addr, {wb_line, 5'b0});
                check("wb_data", txn_q[0].data, wb_data);
                k = 1;
            end
            if (txn_q.size() > k) begin
                check("alloc_write", txn_q[k].wr, 0);
                check("alloc_addr", txn_q[k].addr, {ln, 5'b0});
            end
            m_valid[s][slot] = 1;
            m_dirty[s][slot] = 0;
            m_line[s][slot]  = ln;
            m_data[s][slot]  = fill;
        end
        m_used[s][slot] = now_t;
        rdata = cpu_data_o;
        check("rdata", cpu_data_o, wr ? 32'h0 : m_data[s][slot][w*32 +: 32]);
        if (wr) begin
            m_data[s][slot][w*32 +: 32] = wdata;
            m_dirty[s][slot] = 1;
        end
        @(posedge clk_i); #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        @(negedge clk_i);
        check("idle_stall", cpu_stall_o, 0);
        if (hit) check("hit_no_mem", txn_q.size(), 0);
        check("hit_count", hit_count_o, m_hits % (1 << COUNT_W));
        check("miss_count", miss_count_o, m_misses % (1 << COUNT_W));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0]  rd;
        logic         fs;
        logic [255:0] tmp;
        logic [22:0]  tag;
        rst_i          = 1'b1;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;

        tmp = mem_peek(27'h2);
        tmp[31:0]  = 32'hDEAD_BEEF;
        tmp[95:64] = 32'hDEAD_BEEF;
        mem_m[27'h2] = tmp;

        do_reset();

        // cold read miss with a slow memory
        lat_next = 10;
        access(32'h40, 0, 0, 32'h0, rd, fs);
        check("t1_first_stall", fs, 1);
        check("t1_data", rd, 32'hDEAD_BEEF);
        check("t1_misses", miss_count_o, 1);

        // store hit then read back
        lat_next = 2;
        access(32'h44, 1, 0, 32'h1234_5678, rd, fs);
        check("t2_first_stall", fs, 0);
        check("t2_hits", hit_count_o, 1);
        access(32'h44, 0, 0, 32'h0, rd, fs);
        check("t2_data", rd, 32'h1234_5678);
        access(32'h48, 0, 0, 32'h0, rd, fs);
        check("t2_word2", rd, 32'hDEAD_BEEF);

        // fill second way, then third line in set 2 evicts dirty 0x40
        access(32'h240, 0, 0, 32'h0, rd, fs);
        access(32'h440, 0, 0, 32'h0, rd, fs);
        check("t3_txns", txn_q.size(), 2);
        if (txn_q.size() >= 2) begin
            check("t3_wb_addr", txn_q[0].addr, 32'h40);
            check("t3_wb_word1", txn_q[0].data[63:32], 32'h1234_5678);
            check("t3_alloc_addr", txn_q[1].addr, 32'h440);
        end

        // LRU order: A, B, A, C evicts B
        do_reset();
        lat_next = 1;
        access(32'h40, 0, 0, 32'h0, rd, fs);
        access(32'h240, 0, 0, 32'h0, rd, fs);
        access(32'h40, 0, 0, 32'h0, rd, fs);
        check("t4_a_rehit", fs, 0);
        access(32'h440, 0, 0, 32'h0, rd, fs);
        check("t4_c_txns", txn_q.size(), 1);
        if (txn_q.size() >= 1) check("t4_c_addr", txn_q[0].addr, 32'h440);
        access(32'h40, 0, 0, 32'h0, rd, fs);
        check("t4_a_still_hits", fs, 0);
        access(32'h240, 0, 0, 32'h0, rd, fs);
        check("t4_b_evicted", fs, 1);

        // reset while waiting in ALLOCATE
        do_reset();
        hold_ack = 1;
        @(posedge clk_i); #1;
        cpu_addr_i    = 32'h40;
        cpu_MemRead_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("t5_alloc_en", mem_enable_o, 1);
        check("t5_alloc_stall", cpu_stall_o, 1);
        rst_i = 1'b1;
        #1;
        check("t5_rst_en", mem_enable_o, 0);
        check("t5_rst_stall", cpu_stall_o, 0);
        cpu_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i    = 1'b0;
        hold_ack = 0;
        model_clear();
        access(32'h40, 0, 0, 32'h0, rd, fs);
        check("t5_remiss", fs, 1);

        // hit counter wraps at 2^COUNT_W
        do_reset();
        lat_next = 0;
        access(32'h40, 0, 0, 32'h0, rd, fs);
        for (int i = 0; i < 15; i++) access(32'h40, 0, 0, 32'h0, rd, fs);
        check("t6_hits_15", hit_count_o, 15);
        access(32'h40, 0, 0, 32'h0, rd, fs);
        check("t6_hits_wrap", hit_count_o, 0);

        // randomized traffic with stray acks while idle
        do_reset();
        noise_en = 1;
        for (int i = 0; i < 200; i++) begin
            int unsigned tsel;
            logic [31:0] addr;
            bit wr, both;
            tsel     = $urandom_range(0, 3);
            tag      = (tsel == 3) ? 23'h7F_FFFF : 23'(tsel);
            addr     = {tag, 4'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'b00};
            lat_next = $urandom_range(0, 4);
            wr       = 1'($urandom_range(0, 1));
            both     = ($urandom_range(0, 3) == 0);
            access(addr, wr, both, $urandom, rd, fs);
        end
        noise_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
